audio_bram_ctrl: RTL and testbench

Record/playback controller sitting directly upstream of the sample BRAM (mem1/mem2 instances). In record mode it writes incoming audio samples into the BRAM at sequential addresses and tracks the recording length. In playback mode it reads them back on a sample-rate tick and presents them to the DAC path. It is the only master of the BRAM port.

---
 rtl/audio_bram_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_audio_bram_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_bram_ctrl.sv
// ----------------------------------------------------------------------------
// audio_bram_ctrl
//
// Record/playback controller and sole master of the sample BRAM port.
//
// RECORD: every sample_in_valid strobe produces a one-cycle BRAM write on the
// following cycle, at sequential addresses starting from 0. Recording ends on
// stop, or automatically once the last address has been written.
//
// PLAY: every sample_tick issues a one-cycle BRAM read of the next stored
// sample. RD_LAT cycles later the read data is captured into sample_out,
// together with a one-cycle sample_out_valid strobe. The tick-to-valid
// latency is RD_LAT+2 cycles. With loop high, playback wraps to address 0
// after the last recorded sample; otherwise it returns to IDLE.
//
// Handshake: there is no back-pressure anywhere. sample_in_valid and
// sample_tick are single-cycle strobes that are consumed in the cycle they
// are high, or dropped if the current state does not accept them.
// sample_out_valid is a single-cycle strobe, and sample_out holds its value
// between strobes.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   rec_start          pulse: start recording (IDLE only; wins over play_start)
//   play_start         pulse: start playback (IDLE only, needs rec_len != 0)
//   stop               pulse: abort recording or playback
//   loop               level: wrap playback to address 0 after the last sample
//   sample_in/_valid   ADC sample and its qualifying strobe
//   sample_tick        playback-rate strobe
//   bram_en/we/addr/din BRAM port controls (all registered)
//   bram_dout          BRAM read data, valid RD_LAT cycles after bram_en
//   sample_out/_valid  playback sample and its qualifying strobe
//   recording, playing state flags
//   full               the last recording filled the whole memory
//   rec_len            number of samples held from the last recording
//   dbg_state          current FSM state, for observation and checkers
// ----------------------------------------------------------------------------
module audio_bram_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_in_valid,
  input  logic              sample_tick,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   rec_len,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RECORD    = 2'd1;
  localparam logic [1:0] S_PLAY      = 2'd2;
  localparam logic [1:0] S_PLAY_WAIT = 2'd3;

  // Pointers carry one extra bit so a full memory (2^ADDR_W samples) can be
  // represented in rec_len without wrapping.
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      LAT_CNT  = 2'(RD_LAT);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rd_next;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              bram_en_q, bram_en_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              sample_out_valid_q, sample_out_valid_d;
  logic              recording_q, recording_d;
  logic              playing_q, playing_d;

  assign rd_next = rd_ptr_q + PTR_ONE;

  always_comb begin
    state_d            = state_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    wait_cnt_d         = wait_cnt_q;
    full_d             = full_q;
    rec_len_d          = rec_len_q;
    bram_en_d          = 1'b0;
    bram_we_d          = 1'b0;
    bram_addr_d        = bram_addr_q;
    bram_din_d         = bram_din_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rec_start) begin
          state_d   = S_RECORD;
          wr_ptr_d  = '0;
          full_d    = 1'b0;
          rec_len_d = '0;
        end else if (play_start && (rec_len_q != '0)) begin
          state_d  = S_PLAY;
          rd_ptr_d = '0;
        end
      end

      S_RECORD: begin
        if (stop) begin
          // A sample arriving together with stop is discarded.
          state_d   = S_IDLE;
          rec_len_d = wr_ptr_q;
        end else if (sample_in_valid) begin
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          bram_addr_d = wr_ptr_q[ADDR_W-1:0];
          bram_din_d  = sample_in;
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          if (wr_ptr_q == LAST_PTR) begin
            state_d   = S_IDLE;
            full_d    = 1'b1;
            rec_len_d = DEPTH;
          end
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          bram_en_d   = 1'b1;
          bram_addr_d = rd_ptr_q[ADDR_W-1:0];
          wait_cnt_d  = '0;
          state_d     = S_PLAY_WAIT;
        end
      end

      S_PLAY_WAIT: begin
        if (stop) begin
          // The outstanding read is dropped; no valid strobe follows.
          state_d = S_IDLE;
        end else if (wait_cnt_q == LAT_CNT) begin
          sample_out_d       = bram_dout;
          sample_out_valid_d = 1'b1;
          if (rd_next == rec_len_q) begin
            if (loop) begin
              rd_ptr_d = '0;
              state_d  = S_PLAY;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            rd_ptr_d = rd_next;
            state_d  = S_PLAY;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status flags follow the next state so they change with the transition.
    recording_d = (state_d == S_RECORD);
    playing_d   = (state_d == S_PLAY) || (state_d == S_PLAY_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= S_IDLE;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      wait_cnt_q         <= '0;
      full_q             <= 1'b0;
      rec_len_q          <= '0;
      bram_en_q          <= 1'b0;
      bram_we_q          <= 1'b0;
      bram_addr_q        <= '0;
      bram_din_q         <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      recording_q        <= 1'b0;
      playing_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      wait_cnt_q         <= wait_cnt_d;
      full_q             <= full_d;
      rec_len_q          <= rec_len_d;
      bram_en_q          <= bram_en_d;
      bram_we_q          <= bram_we_d;
      bram_addr_q        <= bram_addr_d;
      bram_din_q         <= bram_din_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      recording_q        <= recording_d;
      playing_q          <= playing_d;
    end
  end

  assign bram_en          = bram_en_q;
  assign bram_we          = bram_we_q;
  assign bram_addr        = bram_addr_q;
  assign bram_din         = bram_din_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign recording        = recording_q;
  assign playing          = playing_q;
  assign full             = full_q;
  assign rec_len          = rec_len_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_audio_bram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_audio_bram_ctrl
//
// Bench for audio_bram_ctrl with ADDR_W=4 (16-sample memory), RD_LAT=1.
// A behavioural BRAM with one cycle of read latency sits on the BRAM port.
// Expected writes, read addresses and playback samples are queued when
// stimulus is driven. A negedge monitor pops them when the DUT produces
// BRAM accesses or output strobes.
// ----------------------------------------------------------------------------
module tb_audio_bram_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
  localparam int TICK_PERIOD = 8;

  // ---------------- clock / reset / signals ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rec_start = 1'b0;
  logic              play_start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_in_valid = 1'b0;
  logic              sample_tick = 1'b0;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout = '0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_out_valid;
  logic              recording;
  logic              playing;
  logic              full;
  logic [ADDR_W:0]   rec_len;
  logic [1:0]        dbg_state;

  always #5 clock = ~clock;

  audio_bram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .loop(loop), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .sample_tick(sample_tick), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .recording(recording), .playing(playing), .full(full), .rec_len(rec_len),
    .dbg_state(dbg_state)
  );

  // ---------------- BRAM model (1-cycle read latency) ----------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

  always @(posedge clock) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout <= mem[bram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
  logic [ADDR_W-1:0]        rd_exp_q[$];
  logic [DATA_W-1:0]        exp_q[$];
  logic [DATA_W-1:0]        rec_data [0:19];

  always @(negedge clock) begin
    logic [ADDR_W+DATA_W-1:0] e_wr;
    logic [ADDR_W-1:0]        e_rd;
    logic [DATA_W-1:0]        e_out;
    if (bram_en && bram_we) begin
      wr_seen++;
      checks++;
      if (wr_exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h din=%0h", bram_addr, bram_din);
      end else begin
        e_wr = wr_exp_q.pop_front();
        if ({bram_addr, bram_din} !== e_wr) begin
          failures++;
          $display("FAIL write addr/din got=%0h/%0h exp=%0h/%0h",
                   bram_addr, bram_din, e_wr[ADDR_W+DATA_W-1:DATA_W], e_wr[DATA_W-1:0]);
        end
      end
    end
    if (bram_en && !bram_we) begin
      rd_seen++;
      checks++;
      if (rd_exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read addr=%0h", bram_addr);
      end else begin
        e_rd = rd_exp_q.pop_front();
        if (bram_addr !== e_rd) begin
          failures++;
          $display("FAIL read_addr got=%0h exp=%0h", bram_addr, e_rd);
        end
      end
    end
    if (sample_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample_out got=%0h", sample_out);
      end else begin
        e_out = exp_q.pop_front();
        if (sample_out !== e_out) begin
          failures++;
          $display("FAIL sample_out got=%0h exp=%0h", sample_out, e_out);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_rec_start();
    rec_start = 1'b1; step(); rec_start = 1'b0;
  endtask

  task automatic pulse_play_start();
    play_start = 1'b1; step(); play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  // Drives one sample strobe; the matching write is queued only if expected.
  task automatic send_sample(input int idx, input bit expect_write);
    sample_in = rec_data[idx];
    sample_in_valid = 1'b1;
    if (expect_write) wr_exp_q.push_back({idx[ADDR_W-1:0], rec_data[idx]});
    step();
    sample_in_valid = 1'b0;
    step();
  endtask

  // Issues one tick, checks tick-to-valid latency, pads to the tick period.
  task automatic play_one(input int addr, input string name);
    int lat;
    rd_exp_q.push_back(addr[ADDR_W-1:0]);
    exp_q.push_back(rec_data[addr]);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    lat = 1;
    while (!sample_out_valid && lat < 12) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== RD_LAT + 2) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, RD_LAT + 2);
    end
    for (int k = lat; k < TICK_PERIOD; k++) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_din, sample_out, sample_out_valid,
         recording, playing, full, rec_len, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs en=%0b we=%0b addr=%0h din=%0h so=%0h sov=%0b rec=%0b play=%0b full=%0b len=%0d st=%0d exp=all_zero",
               bram_en, bram_we, bram_addr, bram_din, sample_out, sample_out_valid,
               recording, playing, full, rec_len, dbg_state);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_play_empty();
    int bad = 0;
    pulse_play_start();
    for (int k = 0; k < 4; k++) begin
      if (playing !== 1'b0 || dbg_state !== 2'd0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL play_empty playing=%0b state=%0d exp playing=0 state=0", playing, dbg_state);
    end
  endtask

  task automatic test_start_priority();
    rec_start = 1'b1;
    play_start = 1'b1;
    step();
    rec_start = 1'b0;
    play_start = 1'b0;
    checks++;
    if (recording !== 1'b1 || playing !== 1'b0) begin
      failures++;
      $display("FAIL start_priority recording=%0b playing=%0b exp 1/0", recording, playing);
    end
    pulse_stop();
    checks++;
    if (recording !== 1'b0 || rec_len !== 5'd0) begin
      failures++;
      $display("FAIL empty_record recording=%0b rec_len=%0d exp 0/0", recording, rec_len);
    end
  endtask

  task automatic test_record_five();
    int w0 = wr_seen;
    for (int i = 0; i < 5; i++) rec_data[i] = 16'(16'h0011 * (i + 1));
    pulse_rec_start();
    for (int i = 0; i < 5; i++) send_sample(i, 1'b1);
    checks++;
    if (recording !== 1'b1) begin
      failures++;
      $display("FAIL recording_before_stop got=%0b exp=1", recording);
    end
    pulse_stop();
    checks++;
    if (recording !== 1'b0 || rec_len !== 5'd5 || full !== 1'b0) begin
      failures++;
      $display("FAIL record_five recording=%0b rec_len=%0d full=%0b exp 0/5/0", recording, rec_len, full);
    end
    checks++;
    if (wr_seen - w0 !== 5) begin
      failures++;
      $display("FAIL record_five_writes got=%0d exp=5", wr_seen - w0);
    end
  endtask

  task automatic test_playback_once();
    int extra = 0;
    loop = 1'b0;
    pulse_play_start();
    checks++;
    if (playing !== 1'b1) begin
      failures++;
      $display("FAIL play_start playing=%0b exp=1", playing);
    end
    for (int i = 0; i < 5; i++) begin
      play_one(i, "playback");
      if (i == 4) begin
        checks++;
        if (playing !== 1'b0 || dbg_state !== 2'd0) begin
          failures++;
          $display("FAIL playback_end playing=%0b state=%0d exp 0/0", playing, dbg_state);
        end
      end
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 0; k < TICK_PERIOD; k++) begin
      if (sample_out_valid || bram_en) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL tick_after_end activity=%0d exp=0", extra);
    end
  endtask

  task automatic test_full();
    int w0 = wr_seen;
    for (int i = 0; i < 20; i++) rec_data[i] = 16'($urandom_range(0, 65535));
    pulse_rec_start();
    for (int i = 0; i < 20; i++) send_sample(i, i < 16);
    checks++;
    if (wr_seen - w0 !== 16) begin
      failures++;
      $display("FAIL full_write_count got=%0d exp=16", wr_seen - w0);
    end
    checks++;
    if (full !== 1'b1 || rec_len !== 5'd16 || recording !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL full_status full=%0b rec_len=%0d recording=%0b state=%0d exp 1/16/0/0",
               full, rec_len, recording, dbg_state);
    end
  endtask

  task automatic test_loop_stop();
    int extra = 0;
    for (int i = 0; i < 3; i++) rec_data[i] = 16'($urandom_range(0, 65535));
    pulse_rec_start();
    for (int i = 0; i < 3; i++) send_sample(i, 1'b1);
    pulse_stop();
    checks++;
    if (rec_len !== 5'd3 || full !== 1'b0) begin
      failures++;
      $display("FAIL loop_record rec_len=%0d full=%0b exp 3/0", rec_len, full);
    end
    loop = 1'b1;
    pulse_play_start();
    for (int i = 0; i < 5; i++) play_one(i % 3, "loop_play");
    checks++;
    if (playing !== 1'b1) begin
      failures++;
      $display("FAIL loop_still_playing got=%0b exp=1", playing);
    end
    // Sixth read is issued, then stopped while it is outstanding.
    rd_exp_q.push_back(4'd2);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (dbg_state !== 2'd3) begin
      failures++;
      $display("FAIL loop_play_wait state=%0d exp=3", dbg_state);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (sample_out_valid || bram_en) extra++;
      step();
    end
    checks++;
    if (extra !== 0 || playing !== 1'b0 || rec_len !== 5'd3) begin
      failures++;
      $display("FAIL stop_in_wait activity=%0d playing=%0b rec_len=%0d exp 0/0/3", extra, playing, rec_len);
    end
    loop = 1'b0;
  endtask

  task automatic test_reset_mid_record();
    int extra = 0;
    for (int i = 0; i < 3; i++) rec_data[i] = 16'($urandom_range(1, 65535));
    pulse_rec_start();
    send_sample(0, 1'b1);
    sample_in = rec_data[1];
    sample_in_valid = 1'b1;
    wr_exp_q.push_back({4'd1, rec_data[1]});
    step();
    // Second write is on the bus now; a third sample arrives with reset.
    sample_in = rec_data[2];
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample_in_valid = 1'b0;
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_din, sample_out, sample_out_valid,
         recording, playing, full, rec_len, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_mid_record en=%0b we=%0b addr=%0h din=%0h rec=%0b len=%0d st=%0d exp=all_zero",
               bram_en, bram_we, bram_addr, bram_din, recording, rec_len, dbg_state);
    end
    for (int k = 0; k < 4; k++) begin
      if (bram_en) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL after_reset_bram_en count=%0d exp=0", extra);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_play_empty();
    test_start_priority();
    test_record_five();
    test_playback_once();
    test_full();
    test_loop_stop();
    test_reset_mid_record();
    repeat (4) step();
    checks++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain wr=%0d rd=%0d out=%0d exp 0/0/0",
               wr_exp_q.size(), rd_exp_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
